// File: rtl/cache_access_driver.sv
// -----------------------------------------------------------------------------
// cache_access_driver
//
// Issues a burst of back-to-back reads to a direct-mapped cache. The burst
// starts at base_addr and advances by a fixed stride. The cache returns a
// registered hit flag one cycle after each read. This block counts hits and
// misses for the burst, and both counts saturate.
//
// Ports
//   clk         in   clock; all state changes on the rising edge
//   rst         in   asynchronous active-high reset
//   start       in   begin a burst (only honoured in IDLE)
//   base_addr   in   first address of the burst
//   stride      in   address increment per access (wraps modulo 2^ADDR_WIDTH)
//   num_access  in   number of reads to issue
//   hit         in   cache hit flag, valid the cycle after read
//   read        out  read enable to the cache
//   addr        out  address to the cache
//   busy        out  burst in progress (ISSUE or DRAIN)
//   done        out  one-cycle pulse when the burst completes
//   hit_count   out  hits in the current/last burst
//   miss_count  out  misses in the current/last burst
// -----------------------------------------------------------------------------
module cache_access_driver #(
   parameter int ADDR_WIDTH  = 11,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [ADDR_WIDTH-1:0]  stride,
   input  logic [COUNT_WIDTH-1:0] num_access,
   input  logic                   hit,
   output logic                   read,
   output logic [ADDR_WIDTH-1:0]  addr,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] hit_count,
   output logic [COUNT_WIDTH-1:0] miss_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;

   state_t                 state;
   logic [ADDR_WIDTH-1:0]  stride_q;
   logic [COUNT_WIDTH-1:0] remaining;
   // read_q is set in each cycle where the cache's hit output belongs to
   // one of our reads.
   logic                   read_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         stride_q   <= '0;
         remaining  <= '0;
         read_q     <= 1'b0;
         read       <= 1'b0;
         addr       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         read_q <= read;
         done   <= 1'b0;

         // Response accounting. read_q is never set in IDLE, so the clear
         // on an accepted start below cannot collide with an increment.
         if (read_q) begin
            if (hit) begin
               if (hit_count != CNT_MAX)
                  hit_count <= hit_count + CNT_ONE;
            end else begin
               if (miss_count != CNT_MAX)
                  miss_count <= miss_count + CNT_ONE;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  stride_q   <= stride;
                  hit_count  <= '0;
                  miss_count <= '0;
                  if (num_access != CNT_ZERO) begin
                     state     <= ISSUE;
                     addr      <= base_addr;
                     read      <= 1'b1;
                     busy      <= 1'b1;
                     remaining <= num_access;
                  end else begin
                     // An empty burst goes straight to the completion pulse.
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end

            ISSUE: begin
               // remaining counts the reads still to present, including the
               // current one. On the last read, addr is held rather than
               // advanced.
               if (remaining == CNT_ONE) begin
                  read  <= 1'b0;
                  state <= DRAIN;
               end else begin
                  addr      <= addr + stride_q;
                  remaining <= remaining - CNT_ONE;
               end
            end

            DRAIN: begin
               // The final response is counted on this edge by the logic above.
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_access_driver.sv
module tb_cache_access_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [10:0] base_addr;
   logic [10:0] stride;
   logic [15:0] num_access;
   logic        hit;
   logic        read;
   logic [10:0] addr;
   logic        busy;
   logic        done;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int checks = 0;
   int errors = 0;

   // Scoreboard: expected addresses and final counts are queued when a
   // burst is launched and popped as the DUT produces them.
   logic [10:0] exp_addr_q[$];
   int          exp_hit_q[$];
   int          exp_miss_q[$];

   cache_access_driver #(.ADDR_WIDTH(11), .COUNT_WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .stride     (stride),
      .num_access (num_access),
      .hit        (hit),
      .read       (read),
      .addr       (addr),
      .busy       (busy),
      .done       (done),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   // Direct-mapped cache model: 16-byte lines, 16 sets (addr[7:4]),
   // tag addr[10:8]. The hit flag is registered and allocation is on a miss.
   logic        cache_clr;
   logic [15:0] valid;
   logic [2:0]  tags [16];
   logic [3:0]  c_idx;
   logic [2:0]  c_tag;
   assign c_idx = addr[7:4];
   assign c_tag = addr[10:8];

   always @(posedge clk) begin
      if (cache_clr) begin
         valid <= '0;
         hit   <= 1'b0;
      end else begin
         hit <= 1'b0;
         if (read) begin
            hit <= valid[c_idx] && (tags[c_idx] == c_tag);
            valid[c_idx] <= 1'b1;
            tags[c_idx]  <= c_tag;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch one burst and follow it to done. When poke is set, a second start
   // with different parameters is pulsed while busy and must have no effect.
   task automatic run_burst(input string name, input logic [10:0] b, input logic [10:0] s,
                            input int n, input int exp_h, input int exp_m, input bit poke);
      logic [10:0] a;
      int reads, busys, done_cyc, exp_done;
      a = b;
      for (int k = 0; k < n; k++) begin
         exp_addr_q.push_back(a);
         a = a + s;
      end
      exp_hit_q.push_back(exp_h);
      exp_miss_q.push_back(exp_m);

      @(posedge clk); #1;
      base_addr  = b;
      stride     = s;
      num_access = 16'(n);
      start      = 1'b1;
      @(posedge clk); #1;             // now in cycle 1
      start      = 1'b0;
      base_addr  = 11'h5A5;
      stride     = 11'h333;
      num_access = 16'd9;

      reads = 0; busys = 0; done_cyc = -1;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         if (read) begin
            reads++;
            if (exp_addr_q.size() > 0)
               check({name, "_addr"}, 32'(addr), 32'(exp_addr_q.pop_front()));
            else
               check({name, "_extra_read"}, 32'(1), 32'(0));
         end
         if (busy) busys++;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (poke && cyc == 2) begin
            start      = 1'b1;
            base_addr  = 11'h7FF;
            num_access = 16'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;

      exp_done = (n == 0) ? 1 : n + 2;
      check({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
      check({name, "_read_cycles"}, 32'(reads), 32'(n));
      check({name, "_busy_cycles"}, 32'(busys), 32'((n == 0) ? 0 : n + 1));
      check({name, "_addr_left"}, 32'(exp_addr_q.size()), 32'(0));
      while (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
      check({name, "_hit_count"}, 32'(hit_count), 32'(exp_hit_q.pop_front()));
      check({name, "_miss_count"}, 32'(miss_count), 32'(exp_miss_q.pop_front()));
      check({name, "_sum"}, 32'(hit_count) + 32'(miss_count), 32'(n));
      @(posedge clk); #1;
      check({name, "_done_pulse"}, 32'(done), 32'(0));
      check({name, "_idle_busy"}, 32'(busy), 32'(0));
   endtask

   task automatic flush_cache();
      @(posedge clk); #1;
      cache_clr = 1'b1;
      @(posedge clk); #1;
      cache_clr = 1'b0;
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_read"}, 32'(read), 32'(0));
      check({name, "_busy"}, 32'(busy), 32'(0));
      check({name, "_done"}, 32'(done), 32'(0));
      check({name, "_addr"}, 32'(addr), 32'(0));
      check({name, "_hit_count"}, 32'(hit_count), 32'(0));
      check({name, "_miss_count"}, 32'(miss_count), 32'(0));
   endtask

   initial begin
      rst        = 1'b1;
      cache_clr  = 1'b1;
      start      = 1'b0;
      base_addr  = '0;
      stride     = '0;
      num_access = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst       = 1'b0;
      cache_clr = 1'b0;

      // Cold cache: 16 distinct lines, all misses.
      run_burst("cold", 11'h000, 11'h010, 16, 0, 16, 1'b0);
      // Same burst again: all hits, with a start pulsed mid-burst.
      run_burst("warm_poke", 11'h000, 11'h010, 16, 16, 0, 1'b1);

      // Conflict pattern on set 2 with tags 0..3, then re-read the survivor.
      flush_cache();
      run_burst("conflict", 11'h020, 11'h100, 4, 0, 4, 1'b0);
      run_burst("stride0", 11'h320, 11'h000, 4, 4, 0, 1'b0);

      // Address wrap: 0x7F0, 0x000, 0x010 (sets 15, 0, 1 are all cold).
      run_burst("wrap", 11'h7F0, 11'h010, 3, 0, 3, 1'b0);

      // Empty burst.
      run_burst("zero", 11'h123, 11'h010, 0, 0, 0, 1'b0);

      // Asynchronous reset in cycle 3 of an 8-access burst.
      @(posedge clk); #1;
      base_addr  = 11'h400;
      stride     = 11'h010;
      num_access = 16'd8;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;             // cycle 3
      check("midrst_read_before", 32'(read), 32'(1));
      check("midrst_busy_before", 32'(busy), 32'(1));
      #2 rst = 1'b1;
      #1;
      check_zero_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_zero_outputs("post_midrst");

      // A later burst runs normally; set 0 and 1 never held tag 5.
      run_burst("after_rst", 11'h500, 11'h010, 2, 0, 2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
